// File: rtl/if_fetch_stage_pkg.sv
// Pipeline-wide fetch types and constants.
// Shared by the fetch stage, its queue and downstream decode.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// IF-stage bus: imem address/data, redirects, ID handshake.
// master = fetch stage, slave = imem/ID/ME side.
interface if_fetch_stage_if #(
  parameter int IMEM_AW = 10
);

  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_instr;
  logic               jump_valid;
  logic [31:0]        jump_target;
  logic               branch_valid;
  logic [31:0]        branch_target;
  logic               id_ready;
  logic               id_valid;
  logic [31:0]        id_instr;
  logic [31:0]        id_pc4;
  logic [15:0]        redirect_cnt;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  jump_valid,
    input  jump_target,
    input  branch_valid,
    input  branch_target,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc4,
    output redirect_cnt
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output jump_valid,
    output jump_target,
    output branch_valid,
    output branch_target,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc4,
    input  redirect_cnt
  );

endinterface

// File: rtl/fetch_queue.sv
// Q_DEPTH-entry FIFO of fetch entries; flush beats push.
// Ports: push/pop/flush in, entry in, full/empty/head/count out.
module fetch_queue
  import if_fetch_stage_pkg::*;
#(
  parameter  int Q_DEPTH = 2,
  localparam int PW      = $clog2(Q_DEPTH),
  localparam int CW      = $clog2(Q_DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  fetch_entry_t  mem_q [Q_DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(Q_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Data storage needs no reset; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= entry_i;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC gen, imem addressing, fetch queue to ID.
// Ports: clk, rst (async low), bus (if_fetch_stage_if.master).
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 10,
  parameter int          Q_DEPTH  = 2,
  localparam int         CW       = $clog2(Q_DEPTH + 1)
) (
  input logic clk,
  input logic rst,
  if_fetch_stage_if.master bus
);

  logic [31:0]   pc_q, pc_d, pc4, target;
  logic [15:0]   rcnt_q;
  logic          redirect, push, pop;
  logic          q_full, q_empty;
  logic [CW-1:0] q_cnt;
  fetch_entry_t  new_e, head;

  assign pc4      = pc_q + 32'd4;
  assign redirect = bus.branch_valid | bus.jump_valid;
  assign pop      = ~q_empty & bus.id_ready;
  assign push     = ~redirect & (~q_full | pop);

  // Branch is older than jump, so it wins.
  always_comb begin
    target = bus.jump_target;
    if (bus.branch_valid) target = bus.branch_target;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = target;
    else if (push) pc_d = pc4;
  end

  assign new_e = '{pc4: pc4, instr: bus.imem_instr};

  fetch_queue #(
    .Q_DEPTH (Q_DEPTH)
  ) u_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .entry_i (new_e),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head),
    .count_o (q_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      rcnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (redirect) rcnt_q <= rcnt_q + 16'd1;
    end
  end

  assign bus.imem_addr    = pc_q[IMEM_AW+1:2];
  assign bus.id_valid     = ~q_empty;
  assign bus.id_instr     = q_empty ? NOP_INSTR : head.instr;
  assign bus.id_pc4       = q_empty ? 32'h0 : head.pc4;
  assign bus.redirect_cnt = rcnt_q;

  a_cnt: assert property (@(posedge clk) disable iff (!rst)
    q_cnt <= CW'(Q_DEPTH));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage.
// Vector table plus reset-in-flight sequence.
module tb_if_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if #(.IMEM_AW(10)) bus ();

  if_fetch_stage #(
    .RESET_PC (32'h0),
    .IMEM_AW  (10),
    .Q_DEPTH  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_instr = 32'h2000_0000 | {20'h0, bus.imem_addr, 2'b00};

  typedef struct packed {
    logic        br;
    logic [31:0] bt;
    logic        jv;
    logic [31:0] jt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc4;
    logic [9:0]  eaddr;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(logic br, logic [31:0] bt, logic jv,
                              logic [31:0] jt, logic rdy, logic ev,
                              logic [31:0] epc4, logic [9:0] eaddr,
                              logic [15:0] ecnt);
    vec_t v;
    v.br = br; v.bt = bt; v.jv = jv; v.jt = jt; v.rdy = rdy;
    v.ev = ev; v.epc4 = epc4; v.eaddr = eaddr; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(int idx, vec_t v);
    logic [31:0] ei;
    ei = v.ev ? (32'h2000_0000 | ((v.epc4 - 32'd4) & 32'hFFC)) : 32'h0;
    chk("id_valid", idx, {31'h0, bus.id_valid}, {31'h0, v.ev});
    chk("id_pc4", idx, bus.id_pc4, v.ev ? v.epc4 : 32'h0);
    chk("id_instr", idx, bus.id_instr, ei);
    chk("imem_addr", idx, {22'h0, bus.imem_addr}, {22'h0, v.eaddr});
    chk("redir_cnt", idx, {16'h0, bus.redirect_cnt}, {16'h0, v.ecnt});
  endtask

  task automatic step(int idx, vec_t v);
    @(negedge clk);
    bus.branch_valid  = v.br;
    bus.branch_target = v.bt;
    bus.jump_valid    = v.jv;
    bus.jump_target   = v.jt;
    bus.id_ready      = v.rdy;
    @(posedge clk);
    #1;
    check_outs(idx, v);
  endtask

  initial begin
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump_valid    = 1'b0;
    bus.jump_target   = 32'h0;
    bus.id_ready      = 1'b0;

    // straight-line stream
    tbl[0]  = mk(0, 0, 0, 0, 1, 1, 32'd4,  10'd1, 16'd0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 1, 32'd8,  10'd2, 16'd0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 1, 32'd12, 10'd3, 16'd0);
    // decode stall: fill then hold
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 32'd12, 10'd4, 16'd0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 32'd12, 10'd4, 16'd0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 32'd12, 10'd4, 16'd0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 32'd12, 10'd4, 16'd0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 32'd12, 10'd4, 16'd0);
    // full with pop each cycle
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 32'd16, 10'd5, 16'd0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 32'd20, 10'd6, 16'd0);
    tbl[10] = mk(0, 0, 0, 0, 1, 1, 32'd24, 10'd7, 16'd0);
    // branch + jump together, branch wins
    tbl[11] = mk(1, 32'h40, 1, 32'h80, 1, 0, 32'h0, 10'h10, 16'd1);
    tbl[12] = mk(0, 0, 0, 0, 1, 1, 32'h44, 10'h11, 16'd1);
    tbl[13] = mk(0, 0, 0, 0, 0, 1, 32'h44, 10'h12, 16'd1);
    // jump during stall; 0x1000 aliases to word 0
    tbl[14] = mk(0, 0, 1, 32'h1000, 0, 0, 32'h0, 10'h0, 16'd2);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 32'h1004, 10'h1, 16'd2);
    tbl[16] = mk(0, 0, 0, 0, 1, 1, 32'h1008, 10'h2, 16'd2);
    // pc wrap from 0xFFFF_FFFC
    tbl[17] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 10'h3FF, 16'd3);
    tbl[18] = mk(0, 0, 0, 0, 1, 1, 32'h0, 10'h0, 16'd3);
    tbl[19] = mk(0, 0, 0, 0, 1, 1, 32'h4, 10'h1, 16'd3);

    repeat (2) @(posedge clk);
    #1;
    check_outs(-1, mk(0, 0, 0, 0, 0, 0, 32'h0, 10'h0, 16'd0));
    @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 20; i++) step(i, tbl[i]);

    // fill queue, then reset mid-cycle
    step(20, mk(0, 0, 0, 0, 0, 1, 32'h4, 10'h2, 16'd3));
    step(21, mk(0, 0, 0, 0, 0, 1, 32'h4, 10'h2, 16'd3));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs(22, mk(0, 0, 0, 0, 0, 0, 32'h0, 10'h0, 16'd0));
    @(posedge clk);
    #2 rst = 1'b1;
    step(23, mk(0, 0, 0, 0, 1, 1, 32'd4, 10'd1, 16'd0));
    step(24, mk(0, 0, 0, 0, 1, 1, 32'd8, 10'd2, 16'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
